// File: rtl/id_ex_stage_pkg.sv
// Shared ALU function codes and datapath defaults for the decode/execute boundary.
// isLegalOp backs the optional IDEX_ILLEGAL_OP_EN opcode screen in id_ex_stage.
package id_ex_stage_pkg;

   localparam int N_DEF  = 32;
   localparam int RA_DEF = 5;

   localparam logic [5:0] ALU_SLL = 6'b000000;
   localparam logic [5:0] ALU_ADD = 6'b100000;
   localparam logic [5:0] ALU_SUB = 6'b100001;
   localparam logic [5:0] ALU_AND = 6'b100100;
   localparam logic [5:0] ALU_OR  = 6'b100101;
   localparam logic [5:0] ALU_XOR = 6'b100110;
   localparam logic [5:0] ALU_NOR = 6'b100111;

   typedef struct packed {
      logic regWrite;
      logic memRead;
      logic memWrite;
   } ctrlT;

   function automatic logic isLegalOp(input logic [5:0] op);
      case (op)
         ALU_SLL, ALU_ADD, ALU_SUB, ALU_AND,
         ALU_OR, ALU_XOR, ALU_NOR: isLegalOp = 1'b1;
         default:                  isLegalOp = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Combinational forwarding select for one operand: EX/MEM wins over MEM/WB,
// which wins over the held register-file value; register 0 always reads 0.
module idex_fwd_mux
   import id_ex_stage_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int RA = RA_DEF
) (
   input  logic [RA-1:0] idx,
   input  logic [N-1:0]  heldVal,
   input  logic          fmWe,
   input  logic [RA-1:0] fmRd,
   input  logic [N-1:0]  fmData,
   input  logic          fwWe,
   input  logic [RA-1:0] fwRd,
   input  logic [N-1:0]  fwData,
   output logic [N-1:0]  value
);

   always_comb begin
      value = heldVal;
      if (idx == '0)
         value = '0;
      else if (fmWe && (fmRd == idx))
         value = fmData;
      else if (fwWe && (fwRd == idx))
         value = fwData;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubbling and
// valid/ready handshakes. Optional macro IDEX_ILLEGAL_OP_EN adds ex_illegal.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int RA = RA_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   output logic          id_ready,
   input  logic [RA-1:0] id_rs,
   input  logic [RA-1:0] id_rt,
   input  logic [RA-1:0] id_rd,
   input  logic [N-1:0]  id_rs_val,
   input  logic [N-1:0]  id_rt_val,
   input  logic [N-1:0]  id_imm,
   input  logic [4:0]    id_shamt,
   input  logic [5:0]    id_alu_op,
   input  logic          id_use_imm,
   input  logic          id_uses_rt,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          flush,
   input  logic          mem_ready,
   input  logic          fm_we,
   input  logic [RA-1:0] fm_rd,
   input  logic [N-1:0]  fm_data,
   input  logic          fw_we,
   input  logic [RA-1:0] fw_rd,
   input  logic [N-1:0]  fw_data,
`ifdef IDEX_ILLEGAL_OP_EN
   output logic          ex_illegal,
`endif
   output logic          ex_valid,
   output logic [N-1:0]  alu_a,
   output logic [N-1:0]  alu_b,
   output logic [5:0]    alu_op,
   output logic [RA-1:0] ex_rd,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic [N-1:0]  ex_store_data
);

   logic          exValid;
   logic [RA-1:0] rsIdx, rtIdx, rdIdx;
   logic [N-1:0]  rsVal, rtVal, immReg;
   logic [4:0]    shamtReg;
   logic [5:0]    opReg;
   logic          useImmReg;
   ctrlT          ctrlReg;

   logic [N-1:0]  fwdRs, fwdRt;
   logic          advance, loadUse, accept, captureOk;

   assign advance  = !exValid || mem_ready;
   assign loadUse  = exValid && ctrlReg.memRead && (rdIdx != '0) &&
                     ((rdIdx == id_rs) || (id_uses_rt && (rdIdx == id_rt)));
   assign id_ready = advance && !loadUse;
   assign accept   = id_valid && id_ready;

`ifdef IDEX_ILLEGAL_OP_EN
   assign captureOk = isLegalOp(id_alu_op);
`else
   assign captureOk = 1'b1;
`endif

   idex_fwd_mux #(.N(N), .RA(RA)) rsMux (
      .idx(rsIdx), .heldVal(rsVal),
      .fmWe(fm_we), .fmRd(fm_rd), .fmData(fm_data),
      .fwWe(fw_we), .fwRd(fw_rd), .fwData(fw_data),
      .value(fwdRs)
   );

   idex_fwd_mux #(.N(N), .RA(RA)) rtMux (
      .idx(rtIdx), .heldVal(rtVal),
      .fmWe(fm_we), .fmRd(fm_rd), .fmData(fm_data),
      .fwWe(fw_we), .fwRd(fw_rd), .fwData(fw_data),
      .value(fwdRt)
   );

   // Flush beats capture; a stalled entry keeps absorbing forwarded results so a
   // producer that retires while we wait is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exValid   <= 1'b0;
         rsIdx     <= '0;
         rtIdx     <= '0;
         rdIdx     <= '0;
         rsVal     <= '0;
         rtVal     <= '0;
         immReg    <= '0;
         shamtReg  <= '0;
         opReg     <= ALU_ADD;
         useImmReg <= 1'b0;
         ctrlReg   <= '0;
      end else if (flush) begin
         exValid <= 1'b0;
      end else if (accept) begin
         exValid   <= captureOk;
         rsIdx     <= id_rs;
         rtIdx     <= id_rt;
         rdIdx     <= id_rd;
         rsVal     <= id_rs_val;
         rtVal     <= id_rt_val;
         immReg    <= id_imm;
         shamtReg  <= id_shamt;
         opReg     <= id_alu_op;
         useImmReg <= id_use_imm;
         ctrlReg   <= '{regWrite: id_reg_write, memRead: id_mem_read, memWrite: id_mem_write};
      end else if (advance) begin
         exValid <= 1'b0;
      end else begin
         rsVal <= fwdRs;
         rtVal <= fwdRt;
      end
   end

`ifdef IDEX_ILLEGAL_OP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ex_illegal <= 1'b0;
      else
         ex_illegal <= !flush && accept && !captureOk;
   end
`endif

   // An empty slot always presents a harmless ADD of zeros with no side effects.
   always_comb begin
      ex_valid      = exValid;
      alu_a         = '0;
      alu_b         = '0;
      alu_op        = ALU_ADD;
      ex_rd         = '0;
      ex_reg_write  = 1'b0;
      ex_mem_read   = 1'b0;
      ex_mem_write  = 1'b0;
      ex_store_data = '0;
      if (exValid) begin
         alu_op        = opReg;
         ex_rd         = rdIdx;
         ex_reg_write  = ctrlReg.regWrite;
         ex_mem_read   = ctrlReg.memRead;
         ex_mem_write  = ctrlReg.memWrite;
         ex_store_data = fwdRt;
         if (opReg == ALU_SLL) begin
            alu_a = fwdRt;
            alu_b = {{(N-5){1'b0}}, shamtReg};
         end else begin
            alu_a = fwdRs;
            alu_b = useImmReg ? immReg : fwdRt;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural pipeline-slot model.
// Follows IDEX_ILLEGAL_OP_EN so it checks whichever build is compiled.
module tb_id_ex_stage;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SLL = 6'b000000;

   logic        clk, rst_n;
   logic        id_valid, id_ready;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_val, id_rt_val, id_imm;
   logic [4:0]  id_shamt;
   logic [5:0]  id_alu_op;
   logic        id_use_imm, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
   logic        flush, mem_ready;
   logic        fm_we, fw_we;
   logic [4:0]  fm_rd, fw_rd;
   logic [31:0] fm_data, fw_data;
   logic        ex_valid;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [5:0]  alu_op;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;
`ifdef IDEX_ILLEGAL_OP_EN
   logic        ex_illegal;
`endif

   int tests = 0;
   int fails = 0;
   bit checkEn = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
      .id_shamt(id_shamt), .id_alu_op(id_alu_op),
      .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .flush(flush), .mem_ready(mem_ready),
      .fm_we(fm_we), .fm_rd(fm_rd), .fm_data(fm_data),
      .fw_we(fw_we), .fw_rd(fw_rd), .fw_data(fw_data),
`ifdef IDEX_ILLEGAL_OP_EN
      .ex_illegal(ex_illegal),
`endif
      .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the single execute slot: what instruction it holds, nothing more
   bit          mValid, mIllegal, mUseImm, mRegW, mMemR, mMemW;
   logic [4:0]  mRs, mRt, mRd, mShamt;
   logic [31:0] mRsVal, mRtVal, mImm;
   logic [5:0]  mOp;

   function automatic bit legalOp(input logic [5:0] op);
      return op inside {6'h20, 6'h21, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00};
   endfunction

   function automatic logic [31:0] regRead(input logic [4:0] idx, input logic [31:0] held);
      if (idx == 5'd0) return 32'd0;
      if (fm_we && fm_rd == idx) return fm_data;
      if (fw_we && fw_rd == idx) return fw_data;
      return held;
   endfunction

   function automatic bit modelLoadUse();
      return mValid && mMemR && mRd != 5'd0 &&
             (mRd == id_rs || (id_uses_rt && mRd == id_rt));
   endfunction

   function automatic bit modelReady();
      return (!mValid || mem_ready) && !modelLoadUse();
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mValid   <= 0;
         mIllegal <= 0;
         mOp      <= OP_ADD;
      end else begin
         mIllegal <= 0;
         if (flush) begin
            mValid <= 0;
         end else if (id_valid && modelReady()) begin
`ifdef IDEX_ILLEGAL_OP_EN
            mValid   <= legalOp(id_alu_op);
            mIllegal <= !legalOp(id_alu_op);
`else
            mValid   <= 1;
`endif
            mRs <= id_rs; mRt <= id_rt; mRd <= id_rd;
            mRsVal <= id_rs_val; mRtVal <= id_rt_val; mImm <= id_imm;
            mShamt <= id_shamt; mOp <= id_alu_op; mUseImm <= id_use_imm;
            mRegW <= id_reg_write; mMemR <= id_mem_read; mMemW <= id_mem_write;
         end else if (!mValid || mem_ready) begin
            mValid <= 0;
         end else begin
            mRsVal <= regRead(mRs, mRsVal);
            mRtVal <= regRead(mRt, mRtVal);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, compare the DUT against the model
   always @(negedge clk) begin
      if (checkEn && rst_n) begin
         logic [31:0] fRs, fRt, expA, expB;
         fRs = regRead(mRs, mRsVal);
         fRt = regRead(mRt, mRtVal);
         checkOutput("id_ready", 32'(id_ready), 32'(modelReady()));
         checkOutput("ex_valid", 32'(ex_valid), 32'(mValid));
`ifdef IDEX_ILLEGAL_OP_EN
         checkOutput("ex_illegal", 32'(ex_illegal), 32'(mIllegal));
`endif
         if (mValid) begin
            if (mOp == OP_SLL) begin
               expA = fRt;
               expB = {27'd0, mShamt};
            end else begin
               expA = fRs;
               expB = mUseImm ? mImm : fRt;
            end
            checkOutput("alu_a", alu_a, expA);
            checkOutput("alu_b", alu_b, expB);
            checkOutput("alu_op", 32'(alu_op), 32'(mOp));
            checkOutput("ex_rd", 32'(ex_rd), 32'(mRd));
            checkOutput("ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
                        {29'd0, mRegW, mMemR, mMemW});
            checkOutput("store_data", ex_store_data, fRt);
         end else begin
            checkOutput("bubble_a", alu_a, 32'd0);
            checkOutput("bubble_b", alu_b, 32'd0);
            checkOutput("bubble_op", 32'(alu_op), 32'(OP_ADD));
            checkOutput("bubble_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; flush = 0; mem_ready = 1; fm_we = 0; fw_we = 0;
      fm_rd = 0; fw_rd = 0; fm_data = 0; fw_data = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_rs_val = 0; id_rt_val = 0; id_imm = 0;
      id_shamt = 0; id_alu_op = OP_ADD; id_use_imm = 0; id_uses_rt = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rs, rt, rd,
                                input logic [31:0] rsv, rtv, imm, input logic [4:0] sh,
                                input bit useImm, usesRt, regW, memR);
      id_valid = 1; id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_val = rsv; id_rt_val = rtv; id_imm = imm; id_shamt = sh;
      id_use_imm = useImm; id_uses_rt = usesRt; id_reg_write = regW;
      id_mem_read = memR; id_mem_write = 0;
   endtask

   task automatic randomCycle();
      logic [5:0] ops [7] = '{6'h20, 6'h21, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00};
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_rs_val    = $urandom;
      id_rt_val    = $urandom;
      id_imm       = $urandom;
      id_shamt     = 5'($urandom_range(0, 31));
      id_alu_op    = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 6)];
      id_use_imm   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1));
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom_range(0, 1));
      flush        = ($urandom_range(0, 19) == 0);
      mem_ready    = ($urandom_range(0, 3) != 0);
      fm_we        = 1'($urandom_range(0, 1));
      fm_rd        = 5'($urandom_range(0, 7));
      fm_data      = $urandom;
      fw_we        = 1'($urandom_range(0, 1));
      fw_rd        = 5'($urandom_range(0, 7));
      fw_data      = $urandom;
   endtask

   initial begin
      rst_n = 0;
      idle();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      checkOutput("reset_valid", 32'(ex_valid), 32'd0);
      checkOutput("reset_op", 32'(alu_op), 32'h20);
      checkOutput("reset_a", alu_a, 32'd0);
      checkOutput("reset_b", alu_b, 32'd0);
      checkEn = 1;
      step();

      // EX/MEM beats MEM/WB on rs; rt untouched
      applyStimulus(OP_ADD, 3, 4, 6, 10, 20, 0, 0, 0, 1, 1, 0);
      step(); idle();
      fm_we = 1; fm_rd = 3; fm_data = 7; fw_we = 1; fw_rd = 3; fw_data = 9;
      @(negedge clk);
      checkOutput("fwd_prio_a", alu_a, 32'd7);
      checkOutput("fwd_prio_b", alu_b, 32'd20);
      step();
      applyStimulus(OP_ADD, 0, 4, 6, 123, 20, 0, 0, 0, 1, 1, 0);
      step(); idle();
      fm_we = 1; fm_rd = 0; fm_data = 7;
      @(negedge clk);
      checkOutput("fwd_r0", alu_a, 32'd0);
      step();

      // Load-use: one stalled cycle, one bubble, then accepted
      idle();
      applyStimulus(OP_ADD, 1, 2, 5, 0, 0, 4, 0, 1, 0, 1, 1);
      step();
      applyStimulus(OP_ADD, 5, 2, 7, 0, 0, 0, 0, 0, 1, 1, 0);
      @(negedge clk);
      checkOutput("lu_stall", 32'(id_ready), 32'd0);
      step();
      @(negedge clk);
      checkOutput("lu_release", 32'(id_ready), 32'd1);
      checkOutput("lu_bubble", 32'(ex_valid), 32'd0);
      step(); idle();
      @(negedge clk);
      checkOutput("lu_accept", 32'(ex_valid), 32'd1);
      checkOutput("lu_rd", 32'(ex_rd), 32'd7);
      step();
      applyStimulus(OP_ADD, 1, 2, 5, 0, 0, 4, 0, 1, 0, 1, 1);
      step();
      applyStimulus(OP_ADD, 1, 5, 7, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("lu_no_rt", 32'(id_ready), 32'd1);
      step(); idle(); step();

      // A MEM/WB write during a stall must be folded into the held operand
      applyStimulus(OP_ADD, 1, 4, 8, 0, 20, 0, 0, 0, 1, 1, 0);
      step(); idle();
      mem_ready = 0; fw_we = 1; fw_rd = 4; fw_data = 55;
      step();
      fw_we = 0;
      step(); step();
      mem_ready = 1;
      @(negedge clk);
      checkOutput("refresh_b", alu_b, 32'd55);
      checkOutput("refresh_valid", 32'(ex_valid), 32'd1);
      step();

      applyStimulus(OP_SLL, 3, 2, 9, 77, 1, 0, 4, 0, 1, 1, 0);
      step(); idle();
      @(negedge clk);
      checkOutput("sll_a", alu_a, 32'd1);
      checkOutput("sll_b", alu_b, 32'd4);
      step();
      applyStimulus(OP_ADD, 1, 2, 3, 5, 6, 0, 0, 0, 1, 1, 0);
      flush = 1;
      step(); idle();
      @(negedge clk);
      checkOutput("flush", 32'(ex_valid), 32'd0);
      step();

      applyStimulus(6'h3f, 1, 2, 3, 5, 6, 0, 0, 0, 1, 1, 0);
      step(); idle();
      @(negedge clk);
`ifdef IDEX_ILLEGAL_OP_EN
      checkOutput("illegal_valid", 32'(ex_valid), 32'd0);
      checkOutput("illegal_flag", 32'(ex_illegal), 32'd1);
      step();
      @(negedge clk);
      checkOutput("illegal_pulse", 32'(ex_illegal), 32'd0);
`else
      checkOutput("passthru_op", 32'(alu_op), 32'h3f);
      checkOutput("passthru_valid", 32'(ex_valid), 32'd1);
`endif
      step();

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            idle();
            applyStimulus(OP_ADD, 1, 2, 3, 5, 6, 0, 0, 0, 1, 1, 0);
            step(); idle();
            mem_ready = 0;
            step();
            rst_n = 0;
            #2;
            checkOutput("reset_mid_stall", 32'(ex_valid), 32'd0);
            #1 rst_n = 1;
            step();
         end
         randomCycle();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
